picoblaze_io_hub: RTL and testbench

Parametrised I/O and interrupt hub between one `pacoblaze3` core and the lab peripherals. It replaces ad-hoc per-design port decoding. It provides:
- NUM_OUT decoded 8-bit output registers with write strobes.
- NUM_IN pipelined input channels.
- An NUM_IRQ-source interrupt controller with edge capture, mask, write-1-to-clear and an acknowledge-latched source ID.

The core's port bus connects directly; peripherals connect to the flattened data vectors.

---
 rtl/picoblaze_io_pkg.sv | 32 +++
 rtl/picoblaze_irq_ctrl.sv | 80 ++++++++
 rtl/picoblaze_io_hub.sv | 110 +++++++++++
 tb/tb_picoblaze_io_hub.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_io_pkg.sv
// ============================================================================
// Module   : picoblaze_io_pkg
// Purpose  : Shared constants and configuration helpers for the PicoBlaze I/O hub.
// Revision : 1.0
// ============================================================================
`default_nettype none

package picoblaze_io_pkg;

   localparam logic [7:0] PORT_IRQ_MASK = 8'hF0;
   localparam logic [7:0] PORT_IRQ_PEND = 8'hF1;
   localparam logic [7:0] PORT_IRQ_ID   = 8'hF2;

   localparam int IRQ_ID_VALID = 7;

   localparam int MAX_NUM_OUT = 16;
   localparam int MAX_NUM_IN  = 16;
   localparam int MAX_NUM_IRQ = 8;

   function automatic bit port_in_range(input int base, input int n, input int port);
      return (port >= base) && (port < base + n);
   endfunction

   function automatic bit ctrl_port_overlap(input int base, input int n);
      return port_in_range(base, n, int'(PORT_IRQ_MASK)) ||
             port_in_range(base, n, int'(PORT_IRQ_PEND)) ||
             port_in_range(base, n, int'(PORT_IRQ_ID));
   endfunction

endpackage

`default_nettype wire

// File: rtl/picoblaze_irq_ctrl.sv
// ============================================================================
// Module   : picoblaze_irq_ctrl
// Purpose  : Edge-capturing interrupt controller with mask, W1C pending and ack ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

module picoblaze_irq_ctrl
   import picoblaze_io_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_src_i,
   input  logic               mask_we_i,
   input  logic               pend_w1c_i,
   input  logic [NUM_IRQ-1:0] wdata_i,
   input  logic               ack_i,
   output logic [NUM_IRQ-1:0] mask_o,
   output logic [NUM_IRQ-1:0] pend_o,
   output logic [7:0]         irq_id_o,
   output logic               interrupt_o
);

   logic [NUM_IRQ-1:0] src_q, prev_q, pend_q, pend_d, mask_q;
   logic [NUM_IRQ-1:0] w_hit, w_ack_clr, w_w1c;
   logic [7:0]         irq_id_q, irq_id_d;
   logic               ack_hold_q, interrupt_q, interrupt_d;

   always_comb begin
      w_hit     = pend_q & mask_q;
      w_ack_clr = '0;
      irq_id_d  = irq_id_q;
      if (ack_i) begin
         irq_id_d = 8'h00;
         // descending scan leaves the lowest active index selected
         for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
               w_ack_clr               = '0;
               w_ack_clr[k]            = 1'b1;
               irq_id_d                = 8'h00;
               irq_id_d[IRQ_ID_VALID]  = 1'b1;
               irq_id_d[2:0]           = 3'(k);
            end
         end
      end
      w_w1c       = pend_w1c_i ? wdata_i : '0;
      pend_d      = (pend_q & ~(w_ack_clr | w_w1c)) | (src_q & ~prev_q);
      interrupt_d = (|w_hit) & ~(ack_i | ack_hold_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_q       <= '0;
         prev_q      <= '0;
         pend_q      <= '0;
         mask_q      <= '1;
         irq_id_q    <= 8'h00;
         ack_hold_q  <= 1'b0;
         interrupt_q <= 1'b0;
      end else begin
         src_q       <= irq_src_i;
         prev_q      <= src_q;
         pend_q      <= pend_d;
         if (mask_we_i) mask_q <= wdata_i;
         irq_id_q    <= irq_id_d;
         ack_hold_q  <= ack_i;
         interrupt_q <= interrupt_d;
      end
   end

   assign mask_o      = mask_q;
   assign pend_o      = pend_q;
   assign irq_id_o    = irq_id_q;
   assign interrupt_o = interrupt_q;

endmodule

`default_nettype wire

// File: rtl/picoblaze_io_hub.sv
// ============================================================================
// Module   : picoblaze_io_hub
// Purpose  : Port decode, output registers, input mux and IRQ controller for pacoblaze3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module picoblaze_io_hub
   import picoblaze_io_pkg::*;
#(
   parameter int         NUM_OUT  = 4,
   parameter int         NUM_IN   = 2,
   parameter int         NUM_IRQ  = 4,
   parameter logic [7:0] OUT_BASE = 8'h80,
   parameter logic [7:0] IN_BASE  = 8'h00
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            port_id,
   input  logic [7:0]            out_port,
   input  logic                  write_strobe,
   input  logic                  read_strobe,
   output logic [7:0]            in_port,
   output logic                  interrupt,
   input  logic                  interrupt_ack,
   input  logic [8*NUM_IN-1:0]   in_data,
   output logic [8*NUM_OUT-1:0]  out_data,
   output logic [NUM_OUT-1:0]    out_wr,
   input  logic [NUM_IRQ-1:0]    irq_src
);

   localparam bit c_CFG_BAD =
      (NUM_OUT < 1) || (NUM_OUT > MAX_NUM_OUT) ||
      (NUM_IN  < 1) || (NUM_IN  > MAX_NUM_IN)  ||
      (NUM_IRQ < 1) || (NUM_IRQ > MAX_NUM_IRQ) ||
      (int'(OUT_BASE) + NUM_OUT > 256) || (int'(IN_BASE) + NUM_IN > 256) ||
      ctrl_port_overlap(int'(OUT_BASE), NUM_OUT) ||
      ctrl_port_overlap(int'(IN_BASE), NUM_IN) ||
      ((int'(OUT_BASE) < int'(IN_BASE) + NUM_IN) && (int'(IN_BASE) < int'(OUT_BASE) + NUM_OUT));

   if (c_CFG_BAD) begin : g_cfg_error
      $error("picoblaze_io_hub: invalid parameters or overlapping port map");
   end

   logic [NUM_OUT-1:0]   w_out_we;
   logic [8*NUM_OUT-1:0] out_data_q;
   logic [NUM_OUT-1:0]   out_wr_q;
   logic [7:0]           in_port_q, in_port_d;
   logic [NUM_IRQ-1:0]   w_irq_mask, w_irq_pend;
   logic [7:0]           w_irq_id;
   logic                 w_unused_read_strobe;

   // read_strobe is informational only: in_port is refreshed every cycle
   assign w_unused_read_strobe = read_strobe;

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_out_dec
      localparam logic [7:0] c_ADDR = 8'(int'(OUT_BASE) + i);
      assign w_out_we[i] = write_strobe && (port_id == c_ADDR);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q <= '0;
         out_wr_q   <= '0;
         in_port_q  <= 8'h00;
      end else begin
         out_wr_q  <= w_out_we;
         in_port_q <= in_port_d;
         for (int i = 0; i < NUM_OUT; i++) begin
            if (w_out_we[i]) out_data_q[8*i +: 8] <= out_port;
         end
      end
   end

   always_comb begin
      in_port_d = 8'h00;
      for (int i = 0; i < NUM_IN; i++) begin
         if (port_id == 8'(int'(IN_BASE) + i)) in_port_d = in_data[8*i +: 8];
      end
      case (port_id)
         PORT_IRQ_MASK: in_port_d = 8'(w_irq_mask);
         PORT_IRQ_PEND: in_port_d = 8'(w_irq_pend);
         PORT_IRQ_ID:   in_port_d = w_irq_id;
         default:       ;
      endcase
   end

   picoblaze_irq_ctrl #(
      .NUM_IRQ (NUM_IRQ)
   ) u_irq_ctrl (
      .clk         (clk),
      .reset_n     (reset_n),
      .irq_src_i   (irq_src),
      .mask_we_i   (write_strobe && (port_id == PORT_IRQ_MASK)),
      .pend_w1c_i  (write_strobe && (port_id == PORT_IRQ_PEND)),
      .wdata_i     (out_port[NUM_IRQ-1:0]),
      .ack_i       (interrupt_ack),
      .mask_o      (w_irq_mask),
      .pend_o      (w_irq_pend),
      .irq_id_o    (w_irq_id),
      .interrupt_o (interrupt)
   );

   assign out_data = out_data_q;
   assign out_wr   = out_wr_q;
   assign in_port  = in_port_q;

endmodule

`default_nettype wire

// File: tb/tb_picoblaze_io_hub.sv
// ============================================================================
// Module   : tb_picoblaze_io_hub
// Purpose  : Directed and randomized self-checking bench for picoblaze_io_hub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_picoblaze_io_hub;

   localparam int         NO  = 4;
   localparam int         NI  = 2;
   localparam int         NQ  = 4;
   localparam logic [7:0] OB  = 8'h80;
   localparam logic [7:0] IB  = 8'h00;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [7:0]      port_id, out_port;
   logic            write_strobe, read_strobe, interrupt_ack;
   logic [7:0]      in_port;
   logic            interrupt;
   logic [8*NI-1:0] in_data;
   logic [8*NO-1:0] out_data;
   logic [NO-1:0]   out_wr;
   logic [NQ-1:0]   irq_src;

   int checks   = 0;
   int failures = 0;

   picoblaze_io_hub #(
      .NUM_OUT (NO), .NUM_IN (NI), .NUM_IRQ (NQ), .OUT_BASE (OB), .IN_BASE (IB)
   ) dut (
      .clk (clk), .reset_n (reset_n), .port_id (port_id), .out_port (out_port),
      .write_strobe (write_strobe), .read_strobe (read_strobe), .in_port (in_port),
      .interrupt (interrupt), .interrupt_ack (interrupt_ack), .in_data (in_data),
      .out_data (out_data), .out_wr (out_wr), .irq_src (irq_src)
   );

   always #5 clk = ~clk;

   // Reference model state: what the hub should hold, by spec rules
   logic [7:0]    m_out [NO];
   logic [NO-1:0] m_wr;
   logic [7:0]    m_in;
   logic          m_int;
   logic [NQ-1:0] m_mask, m_pend;
   logic [7:0]    m_id;
   int            m_age [NQ];   // edges since irq_src[k] was last sampled high/low change
   logic [NQ-1:0] m_seen1, m_seen2;
   logic          m_ack_last;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NO; i++) m_out[i] = 8'h00;
      m_wr = '0; m_in = 8'h00; m_int = 1'b0;
      m_mask = '1; m_pend = '0; m_id = 8'h00;
      m_seen1 = '0; m_seen2 = '0; m_ack_last = 1'b0;
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] p);
      int pi = int'(p);
      if (pi >= int'(IB) && pi < int'(IB) + NI) return in_data[8*(pi-int'(IB)) +: 8];
      if (p == 8'hF0) return 8'(m_mask);
      if (p == 8'hF1) return 8'(m_pend);
      if (p == 8'hF2) return m_id;
      return 8'h00;
   endfunction

   function automatic logic [8*NO-1:0] model_out_flat();
      logic [8*NO-1:0] v = '0;
      for (int i = 0; i < NO; i++) v[8*i +: 8] = m_out[i];
      return v;
   endfunction

   // One rising edge of the hub as seen from the outside
   task automatic model_edge();
      logic [7:0]    nin;
      logic          nint, any_ready;
      int            winner;
      logic [NQ-1:0] npend;
      nin = model_read(port_id);
      any_ready = 1'b0;
      for (int k = 0; k < NQ; k++) if (m_pend[k] && m_mask[k]) any_ready = 1'b1;
      nint = any_ready && !interrupt_ack && !m_ack_last;
      winner = -1;
      if (interrupt_ack)
         for (int k = 0; k < NQ; k++)
            if (winner < 0 && m_pend[k] && m_mask[k]) winner = k;
      for (int k = 0; k < NQ; k++) begin
         bit set_ev = m_seen1[k] && !m_seen2[k];
         bit clr_ev = (k == winner) ||
                      (write_strobe && port_id == 8'hF1 && out_port[k]);
         npend[k] = set_ev ? 1'b1 : (clr_ev ? 1'b0 : m_pend[k]);
      end
      m_wr = '0;
      for (int i = 0; i < NO; i++)
         if (write_strobe && int'(port_id) == int'(OB) + i) begin
            m_out[i] = out_port;
            m_wr[i]  = 1'b1;
         end
      if (interrupt_ack) m_id = (winner >= 0) ? 8'(8'h80 + winner) : 8'h00;
      if (write_strobe && port_id == 8'hF0) m_mask = out_port[NQ-1:0];
      m_ack_last = interrupt_ack;
      m_seen2 = m_seen1;
      m_seen1 = irq_src;
      m_pend  = npend;
      m_int   = nint;
      m_in    = nin;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("cyc_out_data", out_data, model_out_flat());
      chk("cyc_out_wr", 32'(out_wr), 32'(m_wr));
      chk("cyc_in_port", 32'(in_port), 32'(m_in));
      chk("cyc_interrupt", 32'(interrupt), 32'(m_int));
   endtask

   task automatic write_port(input logic [7:0] a, input logic [7:0] d);
      port_id = a; out_port = d; write_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
      read_strobe = 1'b0; interrupt_ack = 1'b0; in_data = '0; irq_src = '0;
      model_reset();
      #2;
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_wr", 32'(out_wr), 32'h0);
      chk("rst_in_port", 32'(in_port), 32'h0);
      chk("rst_interrupt", 32'(interrupt), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      port_id = 8'hF0; read_strobe = 1'b1;
      step();
      chk("rst_mask_rd", 32'(in_port), 32'h0F);

      write_port(8'h82, 8'hA5);
      chk("wr82_data", 32'(out_data[23:16]), 32'hA5);
      chk("wr82_strobe", 32'(out_wr), 32'h4);
      step();
      chk("wr82_pulse_end", 32'(out_wr), 32'h0);
      write_port(8'h84, 8'h77);
      chk("wr84_no_strobe", 32'(out_wr), 32'h0);
      chk("wr84_no_change", out_data, 32'h00A50000);

      in_data = 16'h3C00; port_id = 8'h01;
      step();
      chk("rd_ch1", 32'(in_port), 32'h3C);
      port_id = 8'h55;
      step();
      chk("rd_unmapped", 32'(in_port), 32'h00);

      irq_src = 4'b0100; step();
      irq_src = 4'b0001; step();
      chk("irq_lat_edge2", 32'(interrupt), 32'h0);
      irq_src = 4'b0000; step();
      chk("irq_lat_edge3", 32'(interrupt), 32'h1);
      interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
      chk("ack1_drop", 32'(interrupt), 32'h0);
      port_id = 8'hF2; step();
      chk("ack1_id", 32'(in_port), 32'h80);
      chk("ack1_hold", 32'(interrupt), 32'h0);
      port_id = 8'hF1; step();
      chk("ack1_pend", 32'(in_port), 32'h04);
      chk("ack1_reassert", 32'(interrupt), 32'h1);
      interrupt_ack = 1'b1; port_id = 8'hF2; step(); interrupt_ack = 1'b0;
      chk("ack2_drop", 32'(interrupt), 32'h0);
      step();
      chk("ack2_id", 32'(in_port), 32'h82);
      step();
      chk("ack2_stay_low", 32'(interrupt), 32'h0);

      irq_src = 4'b0010; port_id = 8'hF1;
      repeat (100) step();
      chk("hold_pend_once", 32'(in_port), 32'h02);
      interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
      repeat (5) step();
      chk("hold_after_ack", 32'(in_port), 32'h00);
      chk("hold_int_low", 32'(interrupt), 32'h0);
      irq_src = 4'b0000; step();

      write_port(8'hF0, 8'h00);
      irq_src = 4'b1000; step();
      irq_src = 4'b0000; repeat (3) step();
      port_id = 8'hF1; step();
      chk("masked_pend", 32'(in_port), 32'h08);
      chk("masked_int", 32'(interrupt), 32'h0);
      write_port(8'hF1, 8'h08);
      irq_src = 4'b1000; step();
      write_port(8'hF1, 8'h08);
      irq_src = 4'b0000; step();
      chk("w1c_vs_edge", 32'(in_port), 32'h08);
      write_port(8'hF0, 8'h08);
      chk("unmask_same_edge", 32'(interrupt), 32'h0);
      step();
      chk("unmask_next_edge", 32'(interrupt), 32'h1);
      write_port(8'hF1, 8'h08);
      step();
      chk("w1c_clears", 32'(interrupt), 32'h0);

      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 5))
            0:       port_id = 8'(int'(OB) + $urandom_range(0, 5));
            1:       port_id = 8'(int'(IB) + $urandom_range(0, 3));
            2, 3:    port_id = 8'(8'hF0 + $urandom_range(0, 2));
            4:       port_id = 8'hF3;
            default: port_id = 8'($urandom);
         endcase
         write_strobe  = ($urandom_range(0, 3) == 0);
         out_port      = 8'($urandom);
         interrupt_ack = ($urandom_range(0, 7) == 0);
         in_data       = 16'($urandom);
         if ($urandom_range(0, 2) == 0) irq_src[$urandom_range(0, NQ-1)] ^= 1'b1;
         step();
         if (it == 200) begin
            #3 reset_n = 1'b0;
            #1;
            chk("async_rst_out_data", out_data, 32'h0);
            chk("async_rst_out_wr", 32'(out_wr), 32'h0);
            chk("async_rst_in_port", 32'(in_port), 32'h0);
            chk("async_rst_interrupt", 32'(interrupt), 32'h0);
            model_reset();
            #1 reset_n = 1'b1;
         end
      end
      write_strobe = 1'b0; interrupt_ack = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
